param_bus_proc: RTL and testbench

- Parametrised multicycle bus processor core: a register file, an accumulator-style ALU (A and G registers) and a control FSM sharing one internal data bus.
- Executes one instruction at a time, taken from an external valid/ready instruction port.
- Generalises the fixed 16x16 core in data width and register count, and adds an instruction handshake, a result output port and more ALU operations.
- The internal bus is a registered-source multiplexer; there are no tri-state drivers.

---
 rtl/proc_pkg.sv | 43 ++++
 rtl/proc_regfile.sv | 49 ++++
 rtl/param_bus_proc.sv | 230 +++++++++++++++++++++++
 tb/tb_param_bus_proc.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for param_bus_proc: opcode and FSM state encodings,
// plus the instruction field layout (opcode in the MSBs, then rx, then ry).
package proc_pkg;

    // Opcode field is always 3 bits at the top of the instruction word.
    localparam int OPC_W  = 3;
    // ry occupies the least significant register-index field.
    localparam int RY_LSB = 0;

    typedef enum logic [2:0] {
        OP_LDI = 3'b000,
        OP_MOV = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_OUT = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T1   = 2'd1,
        ST_T2   = 2'd2,
        ST_T3   = 2'd3
    } state_e;

    // rx sits directly above ry.
    function automatic int rx_lsb(input int idx_w);
        return idx_w;
    endfunction

    // Opcode sits directly above rx.
    function automatic int opc_lsb(input int idx_w);
        return 2 * idx_w;
    endfunction

    // ALU ops take the three-cycle A/G path; everything else finishes in T1.
    function automatic logic is_alu_op(input opcode_e op);
        return !(op inside {OP_LDI, OP_MOV, OP_OUT});
    endfunction

endpackage

// File: rtl/proc_regfile.sv
// General register file for param_bus_proc: NUM_REG x DATA_W registers,
// asynchronous active-low reset, one write port and one combinational read
// port that feeds the internal bus multiplexer.
module proc_regfile
    import proc_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NUM_REG = 16,
    parameter int IDX_W   = $clog2(NUM_REG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] regs_q [NUM_REG];
    logic [DATA_W-1:0] regs_d [NUM_REG];

    // Next-state of the array: hold everything, overwrite the addressed entry.
    always_comb begin
        for (int i = 0; i < NUM_REG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[wr_idx] = wr_data;
        end
    end

    // Register storage, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read is straight from the flops, so the bus has a registered source.
    assign rd_data = regs_q[rd_idx];

endmodule

// File: rtl/param_bus_proc.sv
// param_bus_proc: multicycle bus processor with a register file, an A/G
// accumulator ALU and a control FSM sharing one multiplexed internal bus.
// Instructions arrive over a valid/ready port and run one at a time.
// Optional build macro PROC_FLAGS_EN adds zero/carry flag outputs that are
// updated in T2 of ALU operations.
module param_bus_proc
    import proc_pkg::*;
#(
    parameter  int DATA_W    = 16,
    parameter  int NUM_REG   = 16,
    localparam int REG_IDX_W = $clog2(NUM_REG),
    localparam int INSTR_W   = OPC_W + 2 * REG_IDX_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_valid,
    input  logic [DATA_W-1:0]  data_in,
    output logic               instr_ready,
    output logic               done,
    output logic [DATA_W-1:0]  result_out,
    output logic               result_valid
`ifdef PROC_FLAGS_EN
    ,
    output logic               flag_z,
    output logic               flag_c
`endif
);

    localparam int RX_LSB  = rx_lsb(REG_IDX_W);
    localparam int OPC_LSB = opc_lsb(REG_IDX_W);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  g_q, g_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               done_q, done_d;
    logic               rvalid_q, rvalid_d;
`ifdef PROC_FLAGS_EN
    logic               flag_z_q, flag_z_d;
    logic               flag_c_q, flag_c_d;
`endif

    opcode_e              op;
    opcode_e              in_op;
    logic [REG_IDX_W-1:0] rx;
    logic [REG_IDX_W-1:0] ry;

    logic                 rf_we;
    logic [REG_IDX_W-1:0] rf_rd_idx;
    logic [DATA_W-1:0]    rf_rd_data;
    logic [DATA_W-1:0]    rf_wr_data;
    logic                 bus_from_g;
    logic [DATA_W-1:0]    bus;

    // Result of the ALU for a given opcode; wraps modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] alu_res(input opcode_e f,
                                                  input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y);
        case (f)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            default: return '0;
        endcase
    endfunction

`ifdef PROC_FLAGS_EN
    // Carry for ADD is detected by wrap-around of the sum; SUB reports borrow.
    function automatic logic alu_carry(input opcode_e f,
                                       input logic [DATA_W-1:0] x,
                                       input logic [DATA_W-1:0] y,
                                       input logic [DATA_W-1:0] s);
        case (f)
            OP_ADD:  return s < x;
            OP_SUB:  return x < y;
            default: return 1'b0;
        endcase
    endfunction
`endif

    assign op    = opcode_e'(ir_q[OPC_LSB +: OPC_W]);
    assign in_op = opcode_e'(instr_in[OPC_LSB +: OPC_W]);
    assign rx    = ir_q[RX_LSB +: REG_IDX_W];
    assign ry    = ir_q[RY_LSB +: REG_IDX_W];

    assign instr_ready  = (state_q == ST_IDLE);
    assign done         = done_q;
    assign result_out   = result_q;
    assign result_valid = rvalid_q;
`ifdef PROC_FLAGS_EN
    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`endif

    proc_regfile #(
        .DATA_W  (DATA_W),
        .NUM_REG (NUM_REG),
        .IDX_W   (REG_IDX_W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rf_we),
        .wr_idx  (rx),
        .wr_data (rf_wr_data),
        .rd_idx  (rf_rd_idx),
        .rd_data (rf_rd_data)
    );

    // Bus source selection depends only on registered state, so the bus
    // never loops back through the next-state logic.
    always_comb begin
        rf_rd_idx  = rx;
        bus_from_g = 1'b0;
        case (state_q)
            ST_T1: begin
                if (op == OP_MOV) begin
                    rf_rd_idx = ry;
                end
            end
            ST_T2:   rf_rd_idx  = ry;
            ST_T3:   bus_from_g = 1'b1;
            default: ;
        endcase
    end

    assign bus = bus_from_g ? g_q : rf_rd_data;

    // FSM sequencing, datapath next-state and the done/result pulses. The
    // pulses are registered: they are raised on the edge that enters the
    // final execute cycle, so they are high during that cycle.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        imm_d      = imm_q;
        a_d        = a_q;
        g_d        = g_q;
        result_d   = result_q;
        done_d     = 1'b0;
        rvalid_d   = 1'b0;
        rf_we      = 1'b0;
        rf_wr_data = bus;
`ifdef PROC_FLAGS_EN
        flag_z_d   = flag_z_q;
        flag_c_d   = flag_c_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    ir_d     = instr_in;
                    imm_d    = data_in;
                    state_d  = ST_T1;
                    done_d   = !is_alu_op(in_op);
                    rvalid_d = (in_op == OP_OUT);
                end
            end
            ST_T1: begin
                case (op)
                    OP_LDI: begin
                        rf_we      = 1'b1;
                        rf_wr_data = imm_q;
                        state_d    = ST_IDLE;
                    end
                    OP_MOV: begin
                        rf_we   = 1'b1;
                        state_d = ST_IDLE;
                    end
                    OP_OUT: begin
                        result_d = bus;
                        state_d  = ST_IDLE;
                    end
                    default: begin
                        a_d     = bus;
                        state_d = ST_T2;
                    end
                endcase
            end
            ST_T2: begin
                g_d      = alu_res(op, a_q, bus);
`ifdef PROC_FLAGS_EN
                flag_z_d = (g_d == '0);
                flag_c_d = alu_carry(op, a_q, bus, g_d);
`endif
                done_d   = 1'b1;
                state_d  = ST_T3;
            end
            ST_T3: begin
                rf_we   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and datapath registers; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            g_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
`ifdef PROC_FLAGS_EN
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            imm_q    <= imm_d;
            a_q      <= a_d;
            g_q      <= g_d;
            result_q <= result_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
`ifdef PROC_FLAGS_EN
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
`endif
        end
    end

endmodule

// File: tb/tb_param_bus_proc.sv
// Testbench for param_bus_proc: directed and random instruction sequences
// checked against an architectural model (register array, last OUT value,
// flags). A second instance exercises DATA_W=8, NUM_REG=4.
`timescale 1ns/1ps
module tb_param_bus_proc;

    localparam logic [2:0] LDI = 3'd0, MOV = 3'd1, ADD = 3'd2, SUB = 3'd3,
                           ANDO = 3'd4, ORO = 3'd5, XORO = 3'd6, OUT = 3'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [10:0] instr_in;
    logic        instr_valid;
    logic [15:0] data_in;
    logic        instr_ready, done, result_valid;
    logic [15:0] result_out;
`ifdef PROC_FLAGS_EN
    logic        flag_z, flag_c;
    logic        f8_z, f8_c;
`endif

    logic [6:0]  i8_instr;
    logic        i8_valid;
    logic [7:0]  i8_data;
    logic        i8_ready, i8_done, i8_rvalid;
    logic [7:0]  i8_result;

    param_bus_proc dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
        .data_in(data_in), .instr_ready(instr_ready), .done(done),
        .result_out(result_out), .result_valid(result_valid)
`ifdef PROC_FLAGS_EN
        , .flag_z(flag_z), .flag_c(flag_c)
`endif
    );

    param_bus_proc #(.DATA_W(8), .NUM_REG(4)) dut8 (
        .clk(clk), .reset(reset), .instr_in(i8_instr), .instr_valid(i8_valid),
        .data_in(i8_data), .instr_ready(i8_ready), .done(i8_done),
        .result_out(i8_result), .result_valid(i8_rvalid)
`ifdef PROC_FLAGS_EN
        , .flag_z(f8_z), .flag_c(f8_c)
`endif
    );

    // Architectural model state
    logic [15:0] m_reg [16];
    logic [15:0] m_out;
    logic        m_z, m_c;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_alu(input logic [2:0] op);
        return (op >= ADD) && (op <= XORO);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
        m_out = 16'h0;
        m_z   = 1'b0;
        m_c   = 1'b0;
    endfunction

    // Architectural effect of one instruction.
    function automatic void model_exec(input logic [2:0] op, input int rx, input int ry,
                                       input logic [15:0] imm);
        int          x, y, w;
        logic [15:0] r;
        x = int'(m_reg[rx]);
        y = int'(m_reg[ry]);
        r = 16'h0;
        case (op)
            LDI: m_reg[rx] = imm;
            MOV: m_reg[rx] = m_reg[ry];
            OUT: m_out = m_reg[rx];
            default: begin
                case (op)
                    ADD: begin w = x + y; r = 16'(w % 65536); m_c = (w >= 65536); end
                    SUB: begin w = x - y; r = 16'((w + 65536) % 65536); m_c = (x < y); end
                    ANDO: begin r = m_reg[rx] & m_reg[ry]; m_c = 1'b0; end
                    ORO:  begin r = m_reg[rx] | m_reg[ry]; m_c = 1'b0; end
                    default: begin r = m_reg[rx] ^ m_reg[ry]; m_c = 1'b0; end
                endcase
                m_z = (r == 16'h0);
                m_reg[rx] = r;
            end
        endcase
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("ready_before_issue", instr_ready, 1'b1);
    endtask

    // Issue one instruction, check the cycle-level handshake and the results.
    task automatic do_instr(input logic [2:0] op, input int rx, input int ry,
                            input logic [15:0] imm);
        wait_ready();
        instr_in    = {op, 4'(rx), 4'(ry)};
        data_in     = imm;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        instr_in    = 11'($urandom);
        data_in     = 16'($urandom);
        model_exec(op, rx, ry, imm);
        if (is_alu(op)) begin
            chk("alu_t1_done", done, 1'b0);
            chk("alu_t1_ready", instr_ready, 1'b0);
            step();
            chk("alu_t2_done", done, 1'b0);
            step();
            chk("alu_t3_done", done, 1'b1);
            chk("alu_t3_rvalid", result_valid, 1'b0);
            step();
            chk("alu_idle_done", done, 1'b0);
            chk("alu_idle_ready", instr_ready, 1'b1);
        end else begin
            chk("t1_done", done, 1'b1);
            chk("t1_ready", instr_ready, 1'b0);
            chk("t1_rvalid", result_valid, op == OUT);
            step();
            chk("idle_done", done, 1'b0);
            chk("idle_rvalid", result_valid, 1'b0);
        end
        chk("result_out", result_out, m_out);
`ifdef PROC_FLAGS_EN
        chk("flag_z", flag_z, m_z);
        chk("flag_c", flag_c, m_c);
`endif
    endtask

    task automatic do8(input logic [2:0] op, input int rx, input int ry, input logic [7:0] imm);
        int n = 0;
        int lat;
        while (i8_ready !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("w8_ready", i8_ready, 1'b1);
        i8_instr = {op, 2'(rx), 2'(ry)};
        i8_data  = imm;
        i8_valid = 1'b1;
        step();
        i8_valid = 1'b0;
        lat = is_alu(op) ? 3 : 1;
        for (int c = 1; c < lat; c++) step();
        chk("w8_done", i8_done, 1'b1);
        step();
        chk("w8_done_clear", i8_done, 1'b0);
    endtask

    initial begin
        logic [2:0]  rop;
        int          mdst [4];
        int          msrc [4];

        reset       = 1'b0;
        instr_valid = 1'b0;
        instr_in    = '0;
        data_in     = '0;
        i8_valid    = 1'b0;
        i8_instr    = '0;
        i8_data     = '0;
        model_reset();

        // Reset state
        repeat (3) step();
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_rvalid", result_valid, 1'b0);
        chk("rst_result", result_out, 16'h0);
        chk("rst8_ready", i8_ready, 1'b1);
`ifdef PROC_FLAGS_EN
        chk("rst_flag_z", flag_z, 1'b0);
        chk("rst_flag_c", flag_c, 1'b0);
`endif
        reset = 1'b1;
        step();

        // LDI then OUT
        do_instr(LDI, 1, 0, 16'h1234);
        do_instr(OUT, 1, 0, 16'h0);
        chk("out_r1_1234", result_out, 16'h1234);

        // ADD wrap-around
        do_instr(LDI, 2, 0, 16'hFFFF);
        do_instr(LDI, 3, 0, 16'h0001);
        do_instr(ADD, 2, 3, 16'h0);
`ifdef PROC_FLAGS_EN
        chk("add_wrap_z", flag_z, 1'b1);
        chk("add_wrap_c", flag_c, 1'b1);
`endif
        do_instr(OUT, 2, 0, 16'h0);
        chk("add_wrap_val", result_out, 16'h0000);

        // SUB rx,rx and borrow
        do_instr(LDI, 4, 0, 16'h0005);
        do_instr(SUB, 4, 4, 16'h0);
        do_instr(OUT, 4, 0, 16'h0);
        chk("sub_self_zero", result_out, 16'h0000);
        do_instr(LDI, 9, 0, 16'h0001);
        do_instr(SUB, 4, 9, 16'h0);
`ifdef PROC_FLAGS_EN
        chk("sub_borrow_c", flag_c, 1'b1);
`endif
        do_instr(OUT, 4, 0, 16'h0);
        chk("sub_borrow_val", result_out, 16'hFFFF);

        // ADD rx,rx doubles
        do_instr(ADD, 3, 3, 16'h0);
        do_instr(OUT, 3, 0, 16'h0);
        chk("add_self_double", result_out, 16'h0002);

        // Back-to-back MOVs with instr_valid held high
        mdst = '{5, 6, 7, 8};
        msrc = '{1, 5, 3, 6};
        wait_ready();
        instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr_in = {MOV, 4'(mdst[k]), 4'(msrc[k])};
            model_exec(MOV, mdst[k], msrc[k], 16'h0);
            step();
            chk("b2b_t1_done", done, 1'b1);
            chk("b2b_t1_ready", instr_ready, 1'b0);
            step();
            chk("b2b_idle_ready", instr_ready, 1'b1);
            chk("b2b_idle_done", done, 1'b0);
        end
        instr_valid = 1'b0;
        do_instr(OUT, 5, 0, 16'h0);
        chk("mov_r5_1234", result_out, 16'h1234);
        do_instr(OUT, 8, 0, 16'h0);

        // Reset asserted during T2 of an ADD
        do_instr(LDI, 10, 0, 16'h00F0);
        wait_ready();
        instr_in    = {ADD, 4'd10, 4'd10};
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        model_reset();
        chk("midrst_done", done, 1'b0);
        chk("midrst_ready", instr_ready, 1'b1);
        chk("midrst_result", result_out, 16'h0);
        chk("midrst_rvalid", result_valid, 1'b0);
        step();
        step();
        chk("midrst_hold_done", done, 1'b0);
        reset = 1'b1;
        step();
        chk("midrst_post_ready", instr_ready, 1'b1);
        chk("midrst_post_done", done, 1'b0);
        for (int i = 0; i < 16; i++) begin
            do_instr(OUT, i, 0, 16'h0);
        end

        // Random instruction stream
        for (int t = 0; t < 80; t++) begin
            rop = 3'($urandom_range(0, 7));
            do_instr(rop, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 16'($urandom));
        end
        for (int i = 0; i < 16; i++) begin
            do_instr(OUT, i, 0, 16'h0);
        end

        // Narrow configuration: DATA_W=8, NUM_REG=4
        do8(LDI, 3, 0, 8'hA5);
        do8(LDI, 0, 0, 8'hFF);
        do8(XORO, 3, 0, 8'h00);
        do8(OUT, 3, 0, 8'h00);
        chk("w8_xor_result", i8_result, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
